alu_result_fifo: RTL and testbench
==================================

# alu_result_fifo

Downstream capture stage for the 4-bit combinational ALU. Accepts one ALU result plus flags per cycle over a valid/ready handshake and buffers them in a small first-word-fall-through FIFO for the consumer. Maintains sticky status flags and a saturating overflow-event counter across accepted entries. Decouples the single-cycle ALU from a consumer that may stall.

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16
- W, 4, ALU result width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer has an ALU result this cycle
- in_ready  out  1  stage can accept an entry this cycle
- in_op  in  3  OpCode that produced the result (000 ADD … 101 SLT)
- in_result  in  W  ALU Result
- in_slt, in_zero, in_carry, in_ovf  in  1 each  ALU SLT/Zero/Carry/Overflow flags
- out_valid  out  1  head entry present
- out_ready  in  1  consumer takes head entry
- out_data  out  W+7  head entry packed {op[2:0], slt, zero, carry, ovf, result[W-1:0]}
- count  out  $clog2(DEPTH)+1  occupied entries
- clear_sticky  in  1  synchronous clear of sticky flags and counter
- sticky_flags  out  4  {ovf, carry, zero, slt} OR of all accepted entries since last clear
- ovf_events  out  8  accepted entries with ovf=1 since last clear, saturating

## Operation
- Push: in_valid && in_ready at a rising edge writes packed entry to mem[wr_ptr], wr_ptr increments mod DEPTH.
- Pop: out_valid && out_ready at a rising edge advances rd_ptr mod DEPTH.
- in_ready = (count < DEPTH); out_valid = (count != 0); both combinational from registered count.
- out_data = mem[rd_ptr] when out_valid, else all zeros (never X).
- count next = count + push − pop; push and pop in the same cycle leave count unchanged.
- Pointers carry no extra wrap bit; full/empty taken solely from count.
- No bypass: a push into an empty FIFO appears on out_data the next cycle.
- Sticky update per cycle: base = clear_sticky ? 0 : sticky_flags; next = base | (push ? incoming flags : 0). Clear and set in the same cycle → result holds only the new entry's flags.
- ovf_events: base = clear_sticky ? 0 : ovf_events; next = base + (push && in_ovf), saturating at 255.
- Entries are stored verbatim; no re-check of ALU flag consistency.

## Timing
- Reset (async assert, sync release by clk): count=0, pointers=0, out_valid=0, in_ready=1, out_data=0, sticky_flags=0, ovf_events=0. Storage contents not reset; not observable since out_data masked.
- Reset mid-operation discards all buffered entries immediately; in-flight handshakes are lost.
- Latency input→output: 1 cycle when empty; otherwise FIFO order.
- Throughput: 1 entry/cycle sustained with out_ready=1.
- Full (count=DEPTH): in_ready=0, in_valid ignored; pop in that cycle frees a slot visible next cycle.
- Empty (count=0): out_ready ignored.
- Producer must hold in_* stable while in_valid && !in_ready; consumer sees out_data stable while out_valid && !out_ready.

## Configuration
- ALU_CAP_STICKY_EN defined: sticky_flags, ovf_events and clear_sticky behave as above.
- Not defined: sticky/counter registers not built; sticky_flags=0 and ovf_events=0 constantly, clear_sticky ignored. FIFO behaviour identical.

## Test plan
- Reset then push ADD 5+3 (op=000, result=8, all flags 0) with out_ready=0 → next cycle out_valid=1, out_data={000,0,0,0,0,1000}, count=1.
- Push DEPTH=4 entries with out_ready=0 → count=4, in_ready=0; fifth in_valid held 3 cycles not accepted; then one pop → in_ready=1 next cycle, order preserved.
- Steady stream of 20 entries with in_valid=out_ready=1 → one output per cycle, count stays 1, outputs match inputs in order.
- Push ADD 7+1 (ovf=1), SUB 3−10 (carry=1), XOR 10^10 (zero=1) → sticky_flags=4'b1110, ovf_events=1; clear_sticky together with push of SLT −7<2 (slt=1) → sticky_flags=4'b0001, ovf_events=0.
- 300 pushes with ovf=1 → ovf_events saturates at 255 (build with ALU_CAP_STICKY_EN); without macro → stays 0.
- Assert rst_n low with count=3 mid-stream → outputs go to reset values asynchronously before next clock edge; after release, first pushed entry is first out.

Source files
------------

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: FWFT capture FIFO for 4-bit ALU results with flags.
// Optional sticky flags / ovf counter built under ALU_CAP_STICKY_EN.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [W-1:0]             in_result,
  input  logic                     in_slt,
  input  logic                     in_zero,
  input  logic                     in_carry,
  input  logic                     in_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W+6:0]             out_data,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clear_sticky,
  output logic [3:0]               sticky_flags,
  output logic [7:0]               ovf_events
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = W + 7;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_entry;

  assign in_ready  = (r_count < FULL);
  assign out_valid = (r_count != '0);
  assign count     = r_count;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_entry   = {in_op, in_slt, in_zero, in_carry, in_ovf, in_result};
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;

  // Storage is deliberately not reset; the output mux masks it while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Occupancy: push and pop together leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      r_count <= r_count - CW'(1);
    end
  end

`ifdef ALU_CAP_STICKY_EN
  logic [3:0] r_sticky;
  logic [7:0] r_ovf_ev;
  logic [3:0] w_st_base;
  logic [7:0] w_ev_base;
  logic [3:0] w_st_new;

  assign w_st_base = clear_sticky ? 4'b0 : r_sticky;
  assign w_ev_base = clear_sticky ? 8'b0 : r_ovf_ev;
  assign w_st_new  = w_push ?
    {in_ovf, in_carry, in_zero, in_slt} : 4'b0;

  // Clear applies first so a same-cycle push survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
      r_ovf_ev <= '0;
    end else begin
      r_sticky <= w_st_base | w_st_new;
      if (w_push && in_ovf && (w_ev_base != 8'hFF)) begin
        r_ovf_ev <= w_ev_base + 8'd1;
      end else begin
        r_ovf_ev <= w_ev_base;
      end
    end
  end

  assign sticky_flags = r_sticky;
  assign ovf_events   = r_ovf_ev;
`else
  logic w_unused_clear;
  assign w_unused_clear = clear_sticky;
  assign sticky_flags   = 4'b0;
  assign ovf_events     = 8'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: vector table plus scoreboard for alu_result_fifo.
// Sticky expectations follow whether ALU_CAP_STICKY_EN is defined.
module tb_alu_result_fifo;

`ifdef ALU_CAP_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_result;
  logic        in_slt;
  logic        in_zero;
  logic        in_carry;
  logic        in_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;
  logic [2:0]  count;
  logic        clear_sticky;
  logic [3:0]  sticky_flags;
  logic [7:0]  ovf_events;

  alu_result_fifo #(.DEPTH(4), .W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op(in_op),
    .in_result(in_result),
    .in_slt(in_slt),
    .in_zero(in_zero),
    .in_carry(in_carry),
    .in_ovf(in_ovf),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .count(count),
    .clear_sticky(clear_sticky),
    .sticky_flags(sticky_flags),
    .ovf_events(ovf_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  res;
    logic [3:0]  fl;
    logic        clr;
    logic [10:0] exp_data;
    logic [3:0]  exp_st;
    logic [7:0]  exp_ev;
  } vec_t;

  vec_t        vecs [5];
  logic [10:0] sbq [$];
  int          n_pass;
  int          n_total;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [3:0] res, input logic [3:0] fl);
    in_valid  = v;
    in_op     = op;
    in_result = res;
    {in_slt, in_zero, in_carry, in_ovf} = fl;
  endtask

  task automatic cyc();
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) chk("sb_underflow", 32'(out_data), 32'hDEAD);
      else chk("sb_data", 32'(out_data), 32'(sbq.pop_front()));
    end
    if (in_valid && in_ready)
      sbq.push_back({in_op, in_slt, in_zero, in_carry, in_ovf, in_result});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && count != 0; k++) cyc();
    chk("drain_count", 32'(count), 0);
    chk("drain_sb_empty", sbq.size(), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    vecs[0] = '{3'd0, 4'h8, 4'b0000, 1'b0, 11'h008, 4'b0000, 8'd0};
    vecs[1] = '{3'd0, 4'h8, 4'b0001, 1'b0, 11'h018, 4'b1000, 8'd1};
    vecs[2] = '{3'd1, 4'h9, 4'b0010, 1'b0, 11'h129, 4'b1100, 8'd1};
    vecs[3] = '{3'd4, 4'h0, 4'b0100, 1'b0, 11'h440, 4'b1110, 8'd1};
    vecs[4] = '{3'd5, 4'h1, 4'b1000, 1'b1, 11'h581, 4'b0001, 8'd0};

    rst_n        = 1'b0;
    out_ready    = 1'b0;
    clear_sticky = 1'b0;
    drive(1'b0, 3'd0, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_sticky", 32'(sticky_flags), 0);
    chk("rst_ovf_events", 32'(ovf_events), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table: push one entry, inspect head and sticky state, pop it
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].res, vecs[i].fl);
      clear_sticky = vecs[i].clr;
      out_ready    = 1'b0;
      cyc();
      in_valid     = 1'b0;
      clear_sticky = 1'b0;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d_out_data", i), 32'(out_data),
          32'(vecs[i].exp_data));
      chk($sformatf("v%0d_count", i), 32'(count), 1);
      chk($sformatf("v%0d_sticky", i), 32'(sticky_flags),
          STICKY ? 32'(vecs[i].exp_st) : 0);
      chk($sformatf("v%0d_ovf_ev", i), 32'(ovf_events),
          STICKY ? 32'(vecs[i].exp_ev) : 0);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk($sformatf("v%0d_empty", i), 32'(count), 0);
    end

    // fill to DEPTH, hold a fifth entry, then free one slot
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(i), 4'(i + 3), 4'(i));
      cyc();
    end
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    drive(1'b1, 3'd3, 4'hC, 4'b1010);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("hold%0d_in_ready", i), 32'(in_ready), 0);
      chk($sformatf("hold%0d_count", i), 32'(count), 4);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("freed_in_ready", 32'(in_ready), 1);
    chk("freed_count", 32'(count), 3);
    cyc();
    chk("refill_count", 32'(count), 4);
    drain();

    // sustained stream: one in, one out every cycle
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'(i % 6), 4'(i * 7), 4'(i));
      out_ready = 1'b1;
      cyc();
      chk($sformatf("stream%0d_count", i), 32'(count), 1);
    end
    drain();

    // ovf counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 3'd0, 4'(i), 4'b0001);
      clear_sticky = (i == 0);
      out_ready    = 1'b1;
      cyc();
      if (i == 9)
        chk("sat_ovf_10", 32'(ovf_events), STICKY ? 10 : 0);
    end
    clear_sticky = 1'b0;
    chk("sat_ovf_255", 32'(ovf_events), STICKY ? 255 : 0);
    chk("sat_sticky", 32'(sticky_flags), STICKY ? 32'h8 : 0);
    drain();

    // asynchronous reset with three entries buffered
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd2, 4'(i + 1), 4'b0100);
      cyc();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_out_data", 32'(out_data), 0);
    chk("arst_sticky", 32'(sticky_flags), 0);
    chk("arst_ovf_ev", 32'(ovf_events), 0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 3'd3, 4'hE, 4'b0010);
    cyc();
    drive(1'b1, 3'd1, 4'h5, 4'b0000);
    cyc();
    in_valid = 1'b0;
    chk("post_rst_head", 32'(out_data), 32'h32E);
    chk("post_rst_count", 32'(count), 2);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
